uart_number_receiver: RTL and testbench
=======================================

Name: uart_number_receiver

Overview:
- Receive end of the USB serial link (usb_rx).
- Deserialises 8N1 UART bytes and parses ASCII decimal lines, up to 4 digits, into a 14-bit binary value 0..9999.
- The value drives the 7-segment multiplexer's displayed_number input in place of the local counter.
- Counterpart of the display path: the host writes the number, this block decodes it.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per UART bit (100 MHz / 1 Mbaud); must be >= 4.
- MAX_DIGITS, 4, maximum accepted digits per line; the value must fit 14 bits.

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  synchronous reset, active-high
- rx  input  1  asynchronous serial input, idle high
- byte_data  output  8  last correctly received byte
- byte_valid  output  1  one-cycle pulse, byte_data updated
- frame_error  output  1  one-cycle pulse, bad stop bit (or parity, see option)
- number  output  14  last committed value, held between updates
- number_valid  output  1  one-cycle pulse, number updated

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: byte_data=0, byte_valid=0, frame_error=0, number=0, number_valid=0.
  - Internal: FSM=IDLE, accumulator=0, digit count=0, overflow=0.
  - Reset mid-frame abandons the frame; no pulse is emitted.
- Input sync: rx passes through a 2-FF synchronizer, preset to 1 on reset. All decisions use the synchronized signal.
- Receive FSM:
  - IDLE: on synchronized rx=0, load bit counter with CLKS_PER_BIT/2-1 and go to START.
  - START: at the half-bit sample, if rx=1 it is a glitch: return to IDLE, no pulse. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register.
  - STOP: sample once.
    - rx=1: byte_data<=shift, byte_valid=1 for 1 cycle, go to IDLE.
    - rx=0: frame_error=1 for 1 cycle, byte_data unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until synchronized rx=1, then IDLE. No false start on a break condition.
  - Latency: byte_valid rises 1 cycle after the mid-stop-bit sample.
- Line parser (acts on byte_valid only):
  - '0'..'9' (0x30..0x39):
    - count<MAX_DIGITS: acc<=acc*10+digit, count++. Width rule: intermediate is 17 bits, truncated to 14 bits (max 9999).
    - count=MAX_DIGITS: set overflow; acc unchanged.
  - CR (0x0D) or LF (0x0A):
    - count>0 and overflow=0: number<=acc, number_valid=1 for 1 cycle after that byte_valid.
    - Always: clear acc, count, overflow.
    - Empty line, or CR LF pair: second terminator has count=0, no update.
  - Any other byte: clear acc and count, set overflow (line poisoned until terminator).
  - frame_error bytes never reach the parser.
- Simultaneity: byte_valid and frame_error are mutually exclusive. number_valid can coincide with byte_valid of the next byte only if CLKS_PER_BIT is tiny; the parser is single-cycle, so nothing is lost.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. FSM adds a PARITY state after DATA, sampling one extra bit.
  - Even parity check: XOR of data bits and parity bit must be 0.
  - On mismatch: frame_error pulses, byte discarded, go to WAIT_IDLE if rx is low at stop, else IDLE.
- Undefined: 8N1, no PARITY state; behaviour exactly as above.

Test Plan:
- Reset held 3 cycles while rx toggles -> number=0, no pulses; after release, idle rx=1 for 1000 cycles -> no pulses.
- Send "1234\r" at CLKS_PER_BIT=100 -> five byte_valid pulses (0x31,0x32,0x33,0x34,0x0D); number=1234 (0x4D2) with one number_valid pulse, 1 cycle after the CR byte_valid.
- Send "12345\n", then "9999\r\n" -> first line gives no number_valid, number stays at its prior value; second gives number=9999, exactly one number_valid.
- 40-cycle low glitch on rx -> no byte_valid, no frame_error; FSM back in IDLE. A following 0x37 is received correctly.
- Byte 0x35 with stop bit forced 0 and rx held low 500 cycles -> one frame_error pulse, no byte_valid, no new start until rx high. Next "8\r" -> number=8.
- With UART_RX_PARITY_EN: 0x33 with correct even parity bit 0 -> byte_valid; same byte with parity 1 -> frame_error, parser state unaffected.

Source files
------------

// File: rtl/uart_number_receiver.sv
// rtl/uart_number_receiver.sv - 8N1 UART receiver with ASCII decimal line parser (UART_RX_PARITY_EN selects 8E1)
module uart_number_receiver #(
  parameter int CLKS_PER_BIT = 100,
  parameter int MAX_DIGITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_error,
  output logic [13:0] number,
  output logic        number_valid
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int DC_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DC_W-1:0] DIG_MAX = DC_W'(MAX_DIGITS);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  logic par_bad;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta, rx_sync;

  logic [13:0]      acc;
  logic [DC_W-1:0]  count;
  logic             overflow;
  logic [13:0]      acc_next;
  logic             is_digit, is_term;

  // Preset high so reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
`endif
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            cnt   <= BIT_HALF;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_sync) begin
            state <= IDLE;
          end else begin
            cnt     <= BIT_FULL;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift   <= {rx_sync, shift[7:1]};
            cnt     <= BIT_FULL;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_bad <= ^{shift, rx_sync};
            cnt     <= BIT_FULL;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            frame_error <= 1'b1;
            state       <= rx_sync ? IDLE : WAIT_IDLE;
`endif
          end else if (rx_sync) begin
            byte_data  <= shift;
            byte_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            frame_error <= 1'b1;
            state       <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Intermediate product is 17 bits; the digit limit keeps the kept 14 bits exact.
  always_comb begin
    acc_next = 14'({3'b000, acc} * 17'd10 + {13'b0, byte_data[3:0]});
    is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
    is_term  = (byte_data == 8'h0D) || (byte_data == 8'h0A);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      number       <= '0;
      number_valid <= 1'b0;
    end else begin
      number_valid <= 1'b0;
      if (byte_valid) begin
        if (is_digit) begin
          if (count < DIG_MAX) begin
            acc   <= acc_next;
            count <= count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end else if (is_term) begin
          if (count != '0 && !overflow) begin
            number       <= acc;
            number_valid <= 1'b1;
          end
          acc      <= '0;
          count    <= '0;
          overflow <= 1'b0;
        end else begin
          acc      <= '0;
          count    <= '0;
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_number_receiver.sv
// tb/tb_uart_number_receiver.sv - scoreboard bench for uart_number_receiver
module tb_uart_number_receiver;
  localparam int CPB = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        frame_error;
  logic [13:0] number;
  logic        number_valid;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_bytes[$];
  logic [13:0] exp_nums[$];
  logic [7:0]  got_bytes[$];
  logic [13:0] got_nums[$];
  int          got_lat[$];
  int          fe_count = 0;
  int          cyc = 0;
  int          last_bv = 0;

  uart_number_receiver #(.CLKS_PER_BIT(CPB), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .byte_data(byte_data), .byte_valid(byte_valid), .frame_error(frame_error),
    .number(number), .number_valid(number_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (number_valid) begin
      got_nums.push_back(number);
      got_lat.push_back(cyc - last_bv);
    end
    if (byte_valid) begin
      got_bytes.push_back(byte_data);
      last_bv <= cyc;
    end
    if (frame_error) fe_count <= fe_count + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^b) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    bit_time(stop_bit);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      exp_bytes.push_back(8'(s[i]));
      send_frame(8'(s[i]), 1'b1, 1'b0);
    end
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    logic [7:0]  eb;
    logic [13:0] en;
    while (exp_bytes.size() > 0) begin
      eb = exp_bytes.pop_front();
      if (got_bytes.size() == 0) check({tag, " byte missing"}, -1, int'(eb));
      else check({tag, " byte"}, int'(got_bytes.pop_front()), int'(eb));
    end
    check({tag, " extra bytes"}, got_bytes.size(), 0);
    while (exp_nums.size() > 0) begin
      en = exp_nums.pop_front();
      if (got_nums.size() == 0) check({tag, " number missing"}, -1, int'(en));
      else begin
        check({tag, " number"}, int'(got_nums.pop_front()), int'(en));
        check({tag, " number latency"}, got_lat.pop_front(), 1);
      end
    end
    check({tag, " extra numbers"}, got_nums.size(), 0);
    got_bytes.delete();
    got_nums.delete();
    got_lat.delete();
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx = ~rx;
      @(negedge clk);
    end
    check("reset number", int'(number), 0);
    check("reset byte_data", int'(byte_data), 0);
    check("reset pulses", int'({byte_valid, frame_error, number_valid}), 0);
    rx  = 1'b1;
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    check("idle bytes", got_bytes.size(), 0);
    check("idle numbers", got_nums.size(), 0);
    check("idle frame errors", fe_count, 0);

    send_str("1234\015");
    exp_nums.push_back(14'd1234);
    drain("1234");

    send_str("12345\n");
    drain("overflow line");
    check("number held after overflow", int'(number), 1234);

    send_str("9999\015\n");
    exp_nums.push_back(14'd9999);
    drain("9999");

    send_str("\015");
    drain("empty line");
    send_str("1a2\015");
    drain("poisoned line");
    check("number held after poison", int'(number), 9999);

    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch bytes", got_bytes.size(), 0);
    check("glitch frame errors", fe_count, 0);
    send_str("7\n");
    exp_nums.push_back(14'd7);
    drain("after glitch");

    send_frame(8'h35, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (500) @(negedge clk);
    check("break frame errors", fe_count, 1);
    check("break bytes", got_bytes.size(), 0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("break recovery frame errors", fe_count, 1);
    send_str("8\015");
    exp_nums.push_back(14'd8);
    drain("after break");

`ifdef UART_RX_PARITY_EN
    send_str("3");
    send_frame(8'h33, 1'b1, 1'b1);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("parity frame errors", fe_count, 2);
    send_str("\015");
    exp_nums.push_back(14'd3);
    drain("parity");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
